// File: rtl/sram_dual_bank_arbiter.sv
// rtl/sram_dual_bank_arbiter.sv - two-port arbiter and access sequencer for a dual-chip async SRAM bus
//
// Optional build macro: SRAM_ARB_ROUND_ROBIN_EN
//   undefined : port 0 has fixed priority; port 1 is forced through after STARVE_MAX waits
//   defined   : round-robin on a last-granted flag (reset value selects port 0 first)
//
// Every pin-facing output is a flop loaded from next-state values, so the SRAM
// strobes are glitch-free. An access occupies five cycles:
// SETUP, three wait/pulse cycles, then RLATCH or WHOLD. The ack pulse, and rdata
// for reads, are visible during that final cycle.

module sram_dual_bank_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int RD_WAIT    = 3,
    parameter int WR_WAIT    = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_chipset,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_wdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_wdata,
    output logic              p1_ack,
    output logic [7:0]        rdata,
    output logic [18:0]       sram_addr,
    output logic [7:0]        sram_dout,
    input  logic [7:0]        sram_din0,
    input  logic [7:0]        sram_din1,
    output logic              sram0_we_n,
    output logic              sram1_we_n,
    output logic              sram0_doe,
    output logic              sram1_doe
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        RWAIT  = 3'd2,
        RLATCH = 3'd3,
        WPULSE = 3'd4,
        WHOLD  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wcnt;
    logic [3:0]        wcnt_nxt;

    // Access context captured at grant; sram_addr/sram_dout hold the rest.
    logic              gnt_port;
    logic              acc_we;
    logic              acc_oor;
    logic              acc_chip;

    // Arbitration
    logic              elig0;
    logic              elig1;
    logic              pick1;
    logic              do_grant;

    // Values describing the access that will be current after this edge
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [7:0]        sel_wdata;
    logic              nxt_port;
    logic              nxt_we;
    logic              nxt_oor;
    logic              nxt_chip;
    logic              nxt_drive;
    logic              nxt_pulse;
    logic              nxt_ack;

    // A port whose ack is showing is still presenting the finished request.
    assign elig0 = p0_req && !p0_ack;
    assign elig1 = p1_req && !p1_ack;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_gnt;

    // Ties go to the port that was not granted last.
    always_comb begin
        pick1 = 1'b0;
        if (elig1 && (!elig0 || !last_gnt)) begin
            pick1 = 1'b1;
        end
    end

    // Remember which port received the most recent grant.
    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (do_grant) begin
            last_gnt <= pick1;
        end
    end
`else
    logic [3:0] starve_cnt;

    // Port 0 wins unless port 1 has already watched STARVE_MAX port-0 grants.
    always_comb begin
        pick1 = 1'b0;
        if (elig1 && (!elig0 || (starve_cnt == 4'(STARVE_MAX)))) begin
            pick1 = 1'b1;
        end
    end

    // Count port-0 grants that happen while port 1 is kept waiting.
    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (do_grant) begin
            if (pick1 || !p1_req) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    assign sel_addr  = pick1 ? p1_addr  : p0_addr;
    assign sel_we    = pick1 ? p1_we    : p0_we;
    assign sel_wdata = pick1 ? p1_wdata : p0_wdata;

    assign nxt_port  = do_grant ? pick1          : gnt_port;
    assign nxt_we    = do_grant ? sel_we         : acc_we;
    assign nxt_oor   = do_grant ? sel_addr[20]   : acc_oor;
    assign nxt_chip  = do_grant ? sel_addr[19]   : acc_chip;

    // Data is driven SETUP..WHOLD of in-range writes; WE_n is low only in WPULSE.
    assign nxt_drive = nxt_we && !nxt_oor &&
                       ((state_nxt == SETUP) || (state_nxt == WPULSE) || (state_nxt == WHOLD));
    assign nxt_pulse = !nxt_oor && (state_nxt == WPULSE);
    assign nxt_ack   = (state_nxt == RLATCH) || (state_nxt == WHOLD);

    // Next-state logic: grant from IDLE, then count out the wait or pulse phase.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        do_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    do_grant  = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (acc_we) begin
                    state_nxt = WPULSE;
                    wcnt_nxt  = 4'(WR_WAIT - 1);
                end else begin
                    state_nxt = RWAIT;
                    wcnt_nxt  = 4'(RD_WAIT - 1);
                end
            end
            RWAIT: begin
                if (wcnt == 4'd0) begin
                    state_nxt = RLATCH;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            WPULSE: begin
                if (wcnt == 4'd0) begin
                    state_nxt = WHOLD;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            RLATCH:  state_nxt = IDLE;
            WHOLD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, wait counter and the captured access context.
    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wcnt     <= 4'd0;
            gnt_port <= 1'b0;
            acc_we   <= 1'b0;
            acc_oor  <= 1'b0;
            acc_chip <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (do_grant) begin
                gnt_port <= pick1;
                acc_we   <= sel_we;
                acc_oor  <= sel_addr[20];
                acc_chip <= sel_addr[19];
            end
        end
    end

    // Registered SRAM pins, acks and read data.
    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            sram_addr  <= 19'd0;
            sram_dout  <= 8'h00;
            sram0_we_n <= 1'b1;
            sram1_we_n <= 1'b1;
            sram0_doe  <= 1'b0;
            sram1_doe  <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            rdata      <= 8'h00;
        end else begin
            if (do_grant) begin
                sram_addr <= sel_addr[18:0];
                sram_dout <= sel_wdata;
            end
            sram0_we_n <= !(nxt_pulse && nxt_we && !nxt_chip);
            sram1_we_n <= !(nxt_pulse && nxt_we &&  nxt_chip);
            sram0_doe  <= nxt_drive && !nxt_chip;
            sram1_doe  <= nxt_drive &&  nxt_chip;
            p0_ack     <= nxt_ack && !nxt_port;
            p1_ack     <= nxt_ack &&  nxt_port;
            // Capture at the end of the last wait cycle so rdata is valid alongside ack.
            if ((state == RWAIT) && (state_nxt == RLATCH)) begin
                if (acc_oor) begin
                    rdata <= 8'hFF;
                end else if (acc_chip) begin
                    rdata <= sram_din1;
                end else begin
                    rdata <= sram_din0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_dual_bank_arbiter.sv
// tb/tb_sram_dual_bank_arbiter.sv - directed vector bench for sram_dual_bank_arbiter

module tb_sram_dual_bank_arbiter;

    logic        clk_chipset = 1'b0;
    logic        reset       = 1'b1;
    logic        p0_req      = 1'b0;
    logic        p0_we       = 1'b0;
    logic [20:0] p0_addr     = '0;
    logic [7:0]  p0_wdata    = '0;
    logic        p0_ack;
    logic        p1_req      = 1'b0;
    logic        p1_we       = 1'b0;
    logic [20:0] p1_addr     = '0;
    logic [7:0]  p1_wdata    = '0;
    logic        p1_ack;
    logic [7:0]  rdata;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din0   = '0;
    logic [7:0]  sram_din1   = '0;
    logic        sram0_we_n;
    logic        sram1_we_n;
    logic        sram0_doe;
    logic        sram1_doe;

    sram_dual_bank_arbiter dut (
        .clk_chipset (clk_chipset),
        .reset       (reset),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_ack      (p0_ack),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_ack      (p1_ack),
        .rdata       (rdata),
        .sram_addr   (sram_addr),
        .sram_dout   (sram_dout),
        .sram_din0   (sram_din0),
        .sram_din1   (sram_din1),
        .sram0_we_n  (sram0_we_n),
        .sram1_we_n  (sram1_we_n),
        .sram0_doe   (sram0_doe),
        .sram1_doe   (sram1_doe)
    );

    always #5 clk_chipset = ~clk_chipset;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [20:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din0;
        logic [7:0]  din1;
        int          e_we0;
        int          e_we1;
        int          e_doe0;
        int          e_doe1;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs[7];

    // Results of the most recent run_txn
    int          r_ack_at;
    int          r_acks;
    int          r_other;
    int          r_we0;
    int          r_we1;
    int          r_doe0;
    int          r_doe1;
    logic [7:0]  r_rdata;
    logic [18:0] r_addr;
    logic [7:0]  r_dout;

    // One request from one port; observe eight cycles after the request edge.
    task automatic run_txn(input logic port, input logic we, input logic [20:0] addr,
                           input logic [7:0] wdata);
        logic own;
        logic oth;
        r_ack_at = 0; r_acks = 0; r_other = 0;
        r_we0 = 0; r_we1 = 0; r_doe0 = 0; r_doe1 = 0;
        r_rdata = 8'h00; r_addr = '0; r_dout = '0;
        @(posedge clk_chipset); #1;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_chipset); #1;
            own = port ? p1_ack : p0_ack;
            oth = port ? p0_ack : p1_ack;
            if (k == 1) begin
                r_addr = sram_addr;
                r_dout = sram_dout;
            end
            if (!sram0_we_n) r_we0++;
            if (!sram1_we_n) r_we1++;
            if (sram0_doe)   r_doe0++;
            if (sram1_doe)   r_doe1++;
            if (oth)         r_other++;
            if (own) begin
                r_acks++;
                if (r_ack_at == 0) begin
                    r_ack_at = k;
                    r_rdata  = rdata;
                    if (port) p1_req = 1'b0; else p0_req = 1'b0;
                end
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(posedge clk_chipset);
        @(posedge clk_chipset);
        #3 reset = 1'b0;
    endtask

    int   exp_port;
    int   got_port;
    int   waited;
    int   ack_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //           port we   addr       wdata  din0   din1   we0 we1 doe0 doe1 rdata
        vecs[0] = '{1'b1, 1'b1, 21'h00123, 8'hA5, 8'h00, 8'h00, 3, 0, 5, 0, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 21'h80010, 8'h00, 8'h5A, 8'h3C, 0, 0, 0, 0, 8'h3C};
        vecs[2] = '{1'b0, 1'b1, 21'h80200, 8'h5A, 8'h00, 8'h00, 0, 3, 0, 5, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 21'h00123, 8'h00, 8'hC3, 8'h11, 0, 0, 0, 0, 8'hC3};
        vecs[4] = '{1'b0, 1'b1, 21'h100000, 8'h77, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 21'h100000, 8'h00, 8'h12, 8'h34, 0, 0, 0, 0, 8'hFF};
        vecs[6] = '{1'b1, 1'b0, 21'h180001, 8'h00, 8'h56, 8'h78, 0, 0, 0, 0, 8'hFF};

        // Reset state, sampled while reset is held
        @(posedge clk_chipset); #1;
        check("rst_we0_n", sram0_we_n, 1);
        check("rst_we1_n", sram1_we_n, 1);
        check("rst_doe0", sram0_doe, 0);
        check("rst_doe1", sram1_doe, 0);
        check("rst_p0_ack", p0_ack, 0);
        check("rst_p1_ack", p1_ack, 0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_addr", sram_addr, 0);
        check("rst_dout", sram_dout, 0);
        #3 reset = 1'b0;

        // Single transactions from the vector table
        for (int i = 0; i < 7; i++) begin
            sram_din0 = vecs[i].din0;
            sram_din1 = vecs[i].din1;
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_ack_at", i), r_ack_at, 5);
            check($sformatf("v%0d_ack_cnt", i), r_acks, 1);
            check($sformatf("v%0d_other_ack", i), r_other, 0);
            check($sformatf("v%0d_we0_low", i), r_we0, vecs[i].e_we0);
            check($sformatf("v%0d_we1_low", i), r_we1, vecs[i].e_we1);
            check($sformatf("v%0d_doe0", i), r_doe0, vecs[i].e_doe0);
            check($sformatf("v%0d_doe1", i), r_doe1, vecs[i].e_doe1);
            check($sformatf("v%0d_addr", i), r_addr, vecs[i].addr[18:0]);
            if (vecs[i].we)
                check($sformatf("v%0d_dout", i), r_dout, vecs[i].wdata);
            else
                check($sformatf("v%0d_rdata", i), r_rdata, vecs[i].e_rdata);
        end

        // Reset asserted in the middle of a write pulse
        @(posedge clk_chipset); #1;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 21'h00050; p0_wdata = 8'h99;
        repeat (3) @(posedge clk_chipset);
        #1;
        check("mid_we0_low", sram0_we_n, 0);
        check("mid_doe0_high", sram0_doe, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_we0_n", sram0_we_n, 1);
        check("mid_rst_doe0", sram0_doe, 0);
        check("mid_rst_p0_ack", p0_ack, 0);
        check("mid_rst_rdata", rdata, 8'h00);
        p0_req = 1'b0;
        @(posedge clk_chipset);
        @(posedge clk_chipset);
        #3 reset = 1'b0;
        ack_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_chipset); #1;
            if (p0_ack || p1_ack) ack_seen++;
        end
        check("post_rst_no_ack", ack_seen, 0);
        sram_din0 = 8'h77;
        sram_din1 = 8'h00;
        run_txn(1'b1, 1'b0, 21'h00050, 8'h00);
        check("post_rst_ack_at", r_ack_at, 5);
        check("post_rst_rdata", r_rdata, 8'h77);

        // Both ports requesting continuously
        do_reset();
        @(posedge clk_chipset); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 21'h00001;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 21'h00002;
        for (int g = 0; g < 10; g++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            exp_port = g % 2;
`else
            exp_port = ((g % 5) == 4) ? 1 : 0;
`endif
            got_port = -1;
            waited   = 0;
            while (got_port < 0 && waited < 20) begin
                @(posedge clk_chipset); #1;
                waited++;
                if (p0_ack) got_port = 0;
                else if (p1_ack) got_port = 1;
            end
            check($sformatf("arb_grant%0d", g), got_port, exp_port);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (8) @(posedge clk_chipset);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
